// File: rtl/avalon_st_packets_to_bytes_encoder.sv
// Avalon-ST packets-to-bytes encoder.
// Serialises a packet stream (data + channel/SOP/EOP sidebands) into a flat
// byte stream framed with in-band special characters:
//   0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape (next byte XOR 0x20).
// Per beat the emission order is: [channel marker + channel byte], [SOP],
// [EOP], data byte. Channel/data bytes in 0x7A..0x7D are escaped.
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   in_*             - packet-side Avalon-ST sink (ready/valid/data/channel/SOP/EOP)
//   out_*            - byte-side Avalon-ST source (ready/valid/data), registered
module avalon_st_packets_to_bytes_encoder #(
  parameter int CHANNEL_WIDTH       = 8,
  parameter bit EMIT_CHANNEL_ALWAYS = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  // Each state names the byte currently presented on out_data.
  typedef enum logic [2:0] {
    S_IDLE, S_CH, S_CHESC, S_CHVAL, S_SOP, S_EOP, S_DESC, S_DATA
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] out_data_nxt;
  logic       out_valid_nxt;

  logic [7:0] h_data, h_chan;
  logic       h_sop, h_eop;
  logic       chan_known;
  logic [7:0] last_chan;

  logic [7:0] chan_ext;
  logic       capture;
  logic       need_ch;
  state_t     hdata_st;
  logic [7:0] hdata_byte;

  function automatic logic is_special(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

  always_comb begin
    chan_ext = '0;
    chan_ext[CHANNEL_WIDTH-1:0] = in_channel;
  end

  assign in_ready = (state == S_IDLE) || ((state == S_DATA) && out_ready);
  assign capture  = in_valid && in_ready;
  assign need_ch  = !chan_known || (chan_ext != last_chan) ||
                    (EMIT_CHANNEL_ALWAYS && in_startofpacket);

  // Data step of the held beat: escape prefix or the raw byte.
  always_comb begin
    hdata_st   = S_DATA;
    hdata_byte = h_data;
    if (is_special(h_data)) begin
      hdata_st   = S_DESC;
      hdata_byte = 8'h7D;
    end
  end

  // A capture takes priority: it can only happen in S_IDLE or while the
  // final S_DATA byte transfers, so it also retires the previous beat.
  always_comb begin
    state_nxt     = state;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    if (capture) begin
      out_valid_nxt = 1'b1;
      if (need_ch) begin
        state_nxt    = S_CH;
        out_data_nxt = 8'h7C;
      end else if (in_startofpacket) begin
        state_nxt    = S_SOP;
        out_data_nxt = 8'h7A;
      end else if (in_endofpacket) begin
        state_nxt    = S_EOP;
        out_data_nxt = 8'h7B;
      end else if (is_special(in_data)) begin
        state_nxt    = S_DESC;
        out_data_nxt = 8'h7D;
      end else begin
        state_nxt    = S_DATA;
        out_data_nxt = in_data;
      end
    end else if (out_valid && out_ready) begin
      unique case (state)
        S_CH: begin
          if (is_special(h_chan)) begin
            state_nxt    = S_CHESC;
            out_data_nxt = 8'h7D;
          end else begin
            state_nxt    = S_CHVAL;
            out_data_nxt = h_chan;
          end
        end
        S_CHESC: begin
          state_nxt    = S_CHVAL;
          out_data_nxt = h_chan ^ 8'h20;
        end
        S_CHVAL: begin
          if (h_sop) begin
            state_nxt    = S_SOP;
            out_data_nxt = 8'h7A;
          end else if (h_eop) begin
            state_nxt    = S_EOP;
            out_data_nxt = 8'h7B;
          end else begin
            state_nxt    = hdata_st;
            out_data_nxt = hdata_byte;
          end
        end
        S_SOP: begin
          if (h_eop) begin
            state_nxt    = S_EOP;
            out_data_nxt = 8'h7B;
          end else begin
            state_nxt    = hdata_st;
            out_data_nxt = hdata_byte;
          end
        end
        S_EOP: begin
          state_nxt    = hdata_st;
          out_data_nxt = hdata_byte;
        end
        S_DESC: begin
          state_nxt    = S_DATA;
          out_data_nxt = h_data ^ 8'h20;
        end
        default: begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      chan_known <= 1'b0;
      last_chan  <= '0;
      h_data     <= '0;
      h_chan     <= '0;
      h_sop      <= 1'b0;
      h_eop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      if (capture) begin
        h_data     <= in_data;
        h_chan     <= chan_ext;
        h_sop      <= in_startofpacket;
        h_eop      <= in_endofpacket;
        last_chan  <= chan_ext;
        chan_known <= 1'b1;
      end
    end
  end

endmodule

// File: doc/avalon_st_packets_to_bytes_encoder.md
Name: avalon_st_packets_to_bytes_encoder

Overview:
Transmit-side counterpart of the host bridge's bytes-to-packets path. It accepts an Avalon-ST packet stream with channel, start-of-packet and end-of-packet sidebands, and serialises it into a flat byte stream. Framing uses in-band special characters: 0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape. It sits between the packet-side master response path and the byte-side transport (JTAG/UART) feeding the host.

Parameters:
CHANNEL_WIDTH, 8, width of in_channel (1..8); value zero-extended to one channel byte.
EMIT_CHANNEL_ALWAYS, 0, 1 = emit the channel marker on every SOP beat even if the channel is unchanged.

Ports:
clk  input  1  single clock; all logic rising-edge.
reset  input  1  synchronous, active-high reset.
in_ready  output  1  packet-side ready.
in_valid  input  1  packet-side valid.
in_data  input  8  payload byte.
in_channel  input  CHANNEL_WIDTH  channel of beat.
in_startofpacket  input  1  SOP sideband.
in_endofpacket  input  1  EOP sideband.
out_ready  input  1  byte-side ready.
out_valid  output  1  byte-side valid (registered).
out_data  output  8  encoded byte (registered).

Behaviour:
- Reset (reset=1 at an edge): out_valid=0, out_data=0x00, state=S_IDLE, chan_known=0, last_chan=0. in_ready=1 in the cycle after reset deasserts. Reset mid-sequence discards the held beat and any remaining bytes; no partial sequence is resumed.
- Special byte: any value 0x7A..0x7D. Escaping: emit 0x7D, then value XOR 0x20.
- Per accepted beat, emission order is fixed:
  1. Channel: emitted when chan_known=0, or zero-extended in_channel != last_chan, or (EMIT_CHANNEL_ALWAYS=1 and SOP). Output 0x7C, then the channel byte, escaped if special. Update last_chan and set chan_known=1 at beat capture.
  2. If SOP: 0x7A.
  3. If EOP: 0x7B.
  4. Data byte, escaped if special.
- States (each names the byte currently presented on out_data): S_IDLE (out_valid=0), S_CH (0x7C), S_CHESC (0x7D), S_CHVAL, S_SOP, S_EOP, S_DESC (0x7D), S_DATA. Next state is the next required step of the order above; steps not needed are skipped.
- Beat capture: on in_valid & in_ready, register data, channel, SOP and EOP into a holding register, and load the first byte into out_data/out_valid at the same edge.
- Output handshake: a byte transfers on out_valid & out_ready. While out_ready=0, out_data and out_valid hold stable (Avalon-ST rule). out_valid never drops without a transfer, except on reset.
- in_ready = (state==S_IDLE) | (state==S_DATA & out_ready). This is combinational from out_ready, so back-to-back plain beats stream at 1 byte/cycle.
- When the last byte transfers and in_valid=0, the next state is S_IDLE with out_valid=0.
- Latency: beat accepted at edge N -> first encoded byte valid after edge N (cycle N+1). No input-to-output combinational path on out_data/out_valid.
- No packet-integrity checking: missing SOP/EOP is encoded as presented. An SOP+EOP single-beat packet is legal.

Test Plan:
1. Hold reset 3 cycles, then release -> out_valid=0, out_data=0x00, in_ready=1. Then push beat ch=0, data=0x55, SOP=1, EOP=1 with out_ready=1 -> bytes 7C 00 7A 7B 55 on 5 consecutive cycles, then out_valid=0.
2. Same channel, 2-beat packet: data 0x7B (SOP), then data 0x11 (EOP) -> 7A 7D 5B 7B 11, with no channel marker.
3. Channel change to 0x7D with SOP+EOP, data 0x00 -> 7C 7D 5D 7A 7B 00. Then the next beat on ch 0x7D emits no 7C.
4. Backpressure: out_ready=0 for 3 cycles while 0x7D (escape) is presented -> out_data=0x7D and out_valid=1 stable, in_ready=0. After release, the sequence completes with no loss or duplication.
5. Streaming: 4 plain beats (0x01..0x04, same known channel, no SOP/EOP), in_valid=1 and out_ready=1 -> out_data 01 02 03 04 on 4 consecutive cycles, in_ready=1 throughout.
6. Assert reset while S_SOP is presented -> out_valid=0 next cycle. The following beat on ch 0 re-emits 7C 00 (chan_known cleared).
